// File: rtl/rvfi_trace_pkg.sv
// Shared types for the RVFI trace buffer: the stored trace entry layout and
// the bit positions of its status flags.
package rvfi_trace_pkg;

  localparam int NUM_FLAGS = 3;
  localparam int FLAG_TRAP = 0;
  localparam int FLAG_HALT = 1;
  localparam int FLAG_GAP  = 2;

  typedef logic [NUM_FLAGS-1:0] trace_flags_t;

  typedef struct packed {
    logic [63:0]  order;
    logic [31:0]  insn;
    logic [31:0]  pc_rdata;
    logic [31:0]  pc_wdata;
    logic [4:0]   rd_addr;
    logic [31:0]  rd_wdata;
    logic [31:0]  mem_addr;
    logic [3:0]   mem_wmask;
    logic [31:0]  mem_wdata;
    trace_flags_t flags;
  } trace_entry_t;

  localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

  function automatic trace_flags_t make_flags(input logic trap, input logic halt,
                                              input logic gap);
    trace_flags_t f;
    f            = '0;
    f[FLAG_TRAP] = trap;
    f[FLAG_HALT] = halt;
    f[FLAG_GAP]  = gap;
    return f;
  endfunction

endpackage

// File: rtl/rvfi_trace_buffer_fifo.sv
// Generic first-word-fall-through FIFO: the head word is always on rdata
// while empty is low, and a write is visible on rdata no earlier than the next cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when a word leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; level and pointers alone decide what is valid,
  // and leaving the array unreset lets it map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rvfi_trace_buffer.sv
// Captures RVFI retirement packets into a FIFO, replays them over valid/ready,
// and tracks order continuity, x0 writes, halt and overflow drops.
module rvfi_trace_buffer
  import rvfi_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rvfi_valid,
  input  logic [63:0]            rvfi_order,
  input  logic [31:0]            rvfi_insn,
  input  logic                   rvfi_trap,
  input  logic                   rvfi_halt,
  input  logic [31:0]            rvfi_pc_rdata,
  input  logic [31:0]            rvfi_pc_wdata,
  input  logic [4:0]             rvfi_rd_addr,
  input  logic [31:0]            rvfi_rd_wdata,
  input  logic [3:0]             rvfi_mem_wmask,
  input  logic [31:0]            rvfi_mem_addr,
  input  logic [31:0]            rvfi_mem_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output trace_entry_t           out_entry,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   order_error,
  output logic                   rd0_error,
  output logic                   halted
);

  logic         capture;
  logic         pop;
  logic         push;
  logic         drop;
  logic         fifo_full;
  logic         fifo_empty;
  logic         gap_pending;
  logic [63:0]  expected_order;
  trace_entry_t in_entry;

  // After a halt the hart is considered finished; stray strobes are ignored.
  assign capture   = rvfi_valid && !halted;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = capture && (!fifo_full || pop);
  assign drop      = capture && fifo_full && !pop;

  // NOTE: every field gets a default first so this block can never infer a latch.
  always_comb begin
    in_entry           = '0;
    in_entry.order     = rvfi_order;
    in_entry.insn      = rvfi_insn;
    in_entry.pc_rdata  = rvfi_pc_rdata;
    in_entry.pc_wdata  = rvfi_pc_wdata;
    in_entry.rd_addr   = rvfi_rd_addr;
    in_entry.rd_wdata  = rvfi_rd_wdata;
    in_entry.mem_addr  = rvfi_mem_addr;
    in_entry.mem_wmask = rvfi_mem_wmask;
    in_entry.mem_wdata = rvfi_mem_wdata;
    in_entry.flags     = make_flags(rvfi_trap, rvfi_halt, gap_pending);
  end

  sync_fifo #(
    .WIDTH (TRACE_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_entry),
    .rdata (out_entry),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sanity checks run on every capture, dropped packets included.
  always_ff @(posedge clock) begin
    if (reset) begin
      expected_order <= '0;
      order_error    <= 1'b0;
      rd0_error      <= 1'b0;
      halted         <= 1'b0;
    end else if (capture) begin
      expected_order <= rvfi_order + 64'd1;
      if (rvfi_order != expected_order) order_error <= 1'b1;
      if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != 32'd0) rd0_error <= 1'b1;
      if (rvfi_halt) halted <= 1'b1;
    end
  end

  // A drop marks the stream so the next stored entry shows the hole.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count  <= '0;
      gap_pending <= 1'b0;
    end else if (drop) begin
      gap_pending <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
    end else if (push) begin
      gap_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Randomised and directed bench for rvfi_trace_buffer against a queue-based model.
module tb_rvfi_trace_buffer;
  import rvfi_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned DROP_MAX = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              rvfi_valid;
  logic [63:0]       rvfi_order;
  logic [31:0]       rvfi_insn;
  logic              rvfi_trap;
  logic              rvfi_halt;
  logic [31:0]       rvfi_pc_rdata;
  logic [31:0]       rvfi_pc_wdata;
  logic [4:0]        rvfi_rd_addr;
  logic [31:0]       rvfi_rd_wdata;
  logic [3:0]        rvfi_mem_wmask;
  logic [31:0]       rvfi_mem_addr;
  logic [31:0]       rvfi_mem_wdata;
  logic              out_valid;
  logic              out_ready;
  trace_entry_t      out_entry;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  drop_count;
  logic              order_error;
  logic              rd0_error;
  logic              halted;

  rvfi_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_wdata(rvfi_mem_wdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_entry(out_entry), .level(level), .drop_count(drop_count),
    .order_error(order_error), .rd0_error(rd0_error), .halted(halted)
  );

  always #5 clock = ~clock;

  // Reference model state
  trace_entry_t m_q[$];
  int unsigned  m_drop;
  logic [63:0]  m_exp;
  bit           m_gap, m_halted, m_oerr, m_rerr;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic trace_entry_t pkt_from_inputs();
    trace_entry_t e;
    e.order = rvfi_order;         e.insn = rvfi_insn;
    e.pc_rdata = rvfi_pc_rdata;   e.pc_wdata = rvfi_pc_wdata;
    e.rd_addr = rvfi_rd_addr;     e.rd_wdata = rvfi_rd_wdata;
    e.mem_addr = rvfi_mem_addr;   e.mem_wmask = rvfi_mem_wmask;
    e.mem_wdata = rvfi_mem_wdata;
    e.flags = '0;
    e.flags[FLAG_TRAP] = rvfi_trap;
    e.flags[FLAG_HALT] = rvfi_halt;
    return e;
  endfunction

  function automatic void model_clear();
    m_q.delete();
    m_drop = 0; m_exp = '0; m_gap = 0; m_halted = 0; m_oerr = 0; m_rerr = 0;
  endfunction

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic step();
    bit cap, pop, full;
    trace_entry_t e;
    if (reset) begin
      model_clear();
    end else begin
      cap  = rvfi_valid && !m_halted;
      pop  = (m_q.size() != 0) && out_ready;
      full = (m_q.size() == DEPTH);
      e    = pkt_from_inputs();
      if (cap) begin
        if (rvfi_order != m_exp) m_oerr = 1;
        m_exp = rvfi_order + 64'd1;
        if (rvfi_rd_addr == 0 && rvfi_rd_wdata != 0) m_rerr = 1;
      end
      if (pop) void'(m_q.pop_front());
      if (cap && (!full || pop)) begin
        e.flags[FLAG_GAP] = m_gap;
        m_gap = 0;
        m_q.push_back(e);
      end else if (cap) begin
        if (m_drop != DROP_MAX) m_drop++;
        m_gap = 1;
      end
      if (cap && rvfi_halt) m_halted = 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive_pkt(input logic [63:0] order, input logic [4:0] rd_addr,
                           input logic [31:0] rd_wdata, input logic halt);
    rvfi_valid     = 1'b1;
    rvfi_order     = order;
    rvfi_insn      = $urandom;
    rvfi_trap      = 1'b0;
    rvfi_halt      = halt;
    rvfi_pc_rdata  = $urandom;
    rvfi_pc_wdata  = $urandom;
    rvfi_rd_addr   = rd_addr;
    rvfi_rd_wdata  = rd_wdata;
    rvfi_mem_wmask = 4'($urandom);
    rvfi_mem_addr  = $urandom;
    rvfi_mem_wdata = $urandom;
  endtask

  task automatic idle();
    rvfi_valid = 1'b0;
    rvfi_halt  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    do_reset();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_tests++; if (level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_tests++; if (drop_count !== '0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    n_tests++; if ({order_error, rd0_error, halted} !== 3'b000) begin
      n_fail++; $display("FAIL reset_sticky got %b want 000", {order_error, rd0_error, halted});
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    drive_pkt(64'd0, 5'd1, 32'h1234, 1'b0);
    rvfi_insn = 32'h0000_0013;
    step();
    idle();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", out_valid); end
    n_tests++; if (out_entry.insn !== 32'h13 || out_entry.order !== 64'd0 || out_entry.flags !== '0) begin
      n_fail++; $display("FAIL single_fields got insn=%h order=%0d flags=%b want insn=13 order=0 flags=000",
                         out_entry.insn, out_entry.order, out_entry.flags);
    end
    n_tests++; if (out_entry !== m_q[0]) begin n_fail++; $display("FAIL single_entry got %h want %h", out_entry, m_q[0]); end
    step();
    n_tests++; if (level !== '0) begin n_fail++; $display("FAIL single_drain_level got %0d want 0", level); end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_pkt(64'(i), 5'd2, $urandom, 1'b0);
      step();
    end
    idle();
    n_tests++; if (level !== LVL_W'(8)) begin n_fail++; $display("FAIL ovf_level got %0d want 8", level); end
    n_tests++; if (drop_count !== CNT_W'(2)) begin n_fail++; $display("FAIL ovf_drop got %0d want 2", drop_count); end
    n_tests++; if (order_error !== 1'b0) begin n_fail++; $display("FAIL ovf_order_err got %0b want 0", order_error); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (out_valid !== 1'b1 || out_entry.order !== 64'(i) || out_entry.flags[FLAG_GAP] !== 1'b0) begin
        n_fail++; $display("FAIL ovf_drain_%0d got valid=%0b order=%0d gap=%0b want valid=1 order=%0d gap=0",
                           i, out_valid, out_entry.order, out_entry.flags[FLAG_GAP], i);
      end
      step();
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %0b want 0", out_valid); end
    drive_pkt(64'd10, 5'd2, $urandom, 1'b0);
    step();
    idle();
    n_tests++; if (out_entry.order !== 64'd10 || out_entry.flags[FLAG_GAP] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_gap got order=%0d gap=%0b want order=10 gap=1", out_entry.order, out_entry.flags[FLAG_GAP]);
    end
    step();
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 20; i++) begin
      drive_pkt(64'(i), 5'd3, $urandom, 1'b0);
      step();
    end
    idle();
    n_tests++; if (drop_count !== CNT_W'(DROP_MAX)) begin
      n_fail++; $display("FAIL sat_drop got %0d want %0d", drop_count, DROP_MAX);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_pkt(64'(i), 5'd4, $urandom, 1'b0);
      step();
    end
    drive_pkt(64'd8, 5'd4, $urandom, 1'b0);
    out_ready = 1'b1;
    step();
    idle();
    n_tests++; if (level !== LVL_W'(8)) begin n_fail++; $display("FAIL fullpop_level got %0d want 8", level); end
    n_tests++; if (drop_count !== '0) begin n_fail++; $display("FAIL fullpop_drop got %0d want 0", drop_count); end
    for (int i = 1; i <= 8; i++) begin
      n_tests++; if (out_entry.order !== 64'(i) || out_entry.flags[FLAG_GAP] !== 1'b0) begin
        n_fail++; $display("FAIL fullpop_drain_%0d got order=%0d gap=%0b want order=%0d gap=0",
                           i, out_entry.order, out_entry.flags[FLAG_GAP], i);
      end
      step();
    end
  endtask

  task automatic test_checks();
    logic [63:0] ords [3];
    ords = '{64'd0, 64'd1, 64'd3};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_pkt(ords[i], 5'd5, $urandom, 1'b0);
      step();
      n_tests++; if (order_error !== (i == 2)) begin
        n_fail++; $display("FAIL order_chk_%0d got %0b want %0b", i, order_error, (i == 2));
      end
    end
    drive_pkt(64'd4, 5'd0, 32'h5, 1'b0);
    step();
    idle();
    n_tests++; if (rd0_error !== 1'b1) begin n_fail++; $display("FAIL rd0_flag got %0b want 1", rd0_error); end
    n_tests++; if (out_entry.rd_addr !== 5'd0 || out_entry.rd_wdata !== 32'h5) begin
      n_fail++; $display("FAIL rd0_data got rd=%0d wdata=%h want rd=0 wdata=5", out_entry.rd_addr, out_entry.rd_wdata);
    end
    step();
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_pkt(64'(i), 5'd6, $urandom, i == 4);
      step();
    end
    n_tests++; if (halted !== 1'b1 || level !== LVL_W'(5)) begin
      n_fail++; $display("FAIL halt_set got halted=%0b level=%0d want halted=1 level=5", halted, level);
    end
    drive_pkt(64'd5, 5'd6, $urandom, 1'b0);
    step();
    idle();
    n_tests++; if (level !== LVL_W'(5) || drop_count !== '0) begin
      n_fail++; $display("FAIL halt_ignore got level=%0d drop=%0d want level=5 drop=0", level, drop_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_tests++; if (out_entry.order !== 64'd4 || out_entry.flags[FLAG_HALT] !== 1'b1) begin
      n_fail++; $display("FAIL halt_entry got order=%0d halt=%0b want order=4 halt=1", out_entry.order, out_entry.flags[FLAG_HALT]);
    end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    drive_pkt(64'd0, 5'd0, 32'h9, 1'b0);  step();
    drive_pkt(64'd7, 5'd1, 32'h1, 1'b0);  step();
    drive_pkt(64'd8, 5'd1, 32'h2, 1'b1);  step();
    idle();
    n_tests++; if ({order_error, rd0_error, halted} !== 3'b111 || level !== LVL_W'(3)) begin
      n_fail++; $display("FAIL mid_pre got sticky=%b level=%0d want sticky=111 level=3",
                         {order_error, rd0_error, halted}, level);
    end
    reset = 1'b1;
    drive_pkt(64'd9, 5'd0, 32'h3, 1'b0);
    step();
    reset = 1'b0;
    idle();
    n_tests++; if (level !== '0 || out_valid !== 1'b0 || drop_count !== '0 ||
                   {order_error, rd0_error, halted} !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset got level=%0d valid=%0b drop=%0d sticky=%b want 0 0 0 000",
                         level, out_valid, drop_count, {order_error, rd0_error, halted});
    end
    drive_pkt(64'd0, 5'd1, 32'h4, 1'b0);
    step();
    idle();
    n_tests++; if (order_error !== 1'b0 || level !== LVL_W'(1)) begin
      n_fail++; $display("FAIL mid_after got order_err=%0b level=%0d want 0 1", order_error, level);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset     = ($urandom_range(199) == 0);
      out_ready = ($urandom_range(1) == 1);
      if ($urandom_range(9) < 7) begin
        drive_pkt(($urandom_range(15) == 0) ? {$urandom, $urandom} : m_exp,
                  ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
                  ($urandom_range(3) == 0) ? 32'd0 : $urandom,
                  ($urandom_range(299) == 0));
        rvfi_trap = 1'($urandom);
      end else begin
        idle();
      end
      step();
      n_tests++; if (out_valid !== (m_q.size() != 0) || level !== LVL_W'(m_q.size()) ||
                     drop_count !== CNT_W'(m_drop)) begin
        n_fail++; $display("FAIL rand_occ cyc=%0d got valid=%0b level=%0d drop=%0d want %0b %0d %0d",
                           cyc, out_valid, level, drop_count, (m_q.size() != 0), m_q.size(), m_drop);
      end
      n_tests++; if ({order_error, rd0_error, halted} !== {m_oerr, m_rerr, m_halted}) begin
        n_fail++; $display("FAIL rand_sticky cyc=%0d got %b want %b", cyc,
                           {order_error, rd0_error, halted}, {m_oerr, m_rerr, m_halted});
      end
      if (m_q.size() != 0) begin
        n_tests++; if (out_entry !== m_q[0]) begin
          n_fail++; $display("FAIL rand_head cyc=%0d got %h want %h", cyc, out_entry, m_q[0]);
        end
      end
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    drive_pkt(64'd0, 5'd0, 32'd0, 1'b0);
    idle();
    model_clear();
    test_reset();
    test_single();
    test_overflow();
    test_saturate();
    test_full_pop();
    test_checks();
    test_halt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
